// File: rtl/cpu_types_pkg.sv
// Shared CPU types.
//   word_t          : 32-bit machine word used for addresses and data.
//   arb_state_t     : memory arbiter grant state (IDLE, IBUSY, DBUSY).
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IBUSY = 2'd1,
    DBUSY = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates a single-ported RAM between an instruction fetch port and a data port.
// Data requests normally win. After STARVE_MAX consecutive data grants taken while a fetch
// was waiting, the next grant goes to the fetch. At least one IDLE cycle separates accesses.
//
// Ports
//   CLK, nRST            : clock (rising edge), synchronous active-low reset
//   iREN, iaddr          : instruction fetch request and address
//   iwait, iload         : fetch not complete / fetched word
//   dREN, dWEN           : data read / write request
//   daddr, dstore        : data address / write data
//   dwait, dload         : data access not complete / read data
//   ramREN, ramWEN       : RAM read / write strobes
//   ramaddr, ramstore    : RAM address / write data
//   ramload, ram_ready   : RAM read data / access completes this cycle
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic  CLK,
  input  logic  nRST,
  input  logic  iREN,
  input  word_t iaddr,
  output logic  iwait,
  output word_t iload,
  input  logic  dREN,
  input  logic  dWEN,
  input  word_t daddr,
  input  word_t dstore,
  output logic  dwait,
  output word_t dload,
  output logic  ramREN,
  output logic  ramWEN,
  output word_t ramaddr,
  output word_t ramstore,
  input  word_t ramload,
  input  logic  ram_ready
);

  localparam int unsigned CntW = $clog2(STARVE_MAX + 1);
  localparam logic [CntW-1:0] StarveMax = CntW'(STARVE_MAX);

  arb_state_t      r_state;
  arb_state_t      w_state_next;
  logic [CntW-1:0] r_streak;
  logic [CntW-1:0] w_streak_next;
  logic            w_dreq;

  assign w_dreq = dREN | dWEN;

  // State and streak registers
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state  <= IDLE;
      r_streak <= '0;
    end else begin
      r_state  <= w_state_next;
      r_streak <= w_streak_next;
    end
  end

  // Next-state and streak update
  always_comb begin
    w_state_next  = r_state;
    w_streak_next = r_streak;
    unique case (r_state)
      IDLE: begin
        if (!iREN) begin
          w_streak_next = '0;
        end
        // Data wins unless the fetch has already been passed over STARVE_MAX times.
        if (w_dreq && !(iREN && (r_streak == StarveMax))) begin
          w_state_next = DBUSY;
        end else if (iREN) begin
          w_state_next = IBUSY;
        end
      end
      IBUSY: begin
        if (ram_ready) begin
          w_state_next  = IDLE;
          w_streak_next = '0;
        end else if (!iREN) begin
          // Requester withdrew: abandon without completion or counter change.
          w_state_next = IDLE;
        end
      end
      DBUSY: begin
        if (ram_ready) begin
          w_state_next = IDLE;
          if (iREN && (r_streak != StarveMax)) begin
            w_streak_next = r_streak + 1'b1;
          end
        end else if (!w_dreq) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = 1'b1;
    dwait    = 1'b1;
    unique case (r_state)
      IDLE: begin
      end
      IBUSY: begin
        ramREN  = 1'b1;
        ramaddr = iaddr;
        iwait   = ~ram_ready;
      end
      DBUSY: begin
        // Write wins when both strobes are asserted.
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        dwait    = ~ram_ready;
      end
      default: begin
      end
    endcase
  end

  assign iload = ramload;
  assign dload = ramload;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int SM = 4;

  logic  CLK;
  logic  nRST;
  logic  iREN, dREN, dWEN, ram_ready;
  word_t iaddr, daddr, dstore, ramload;
  logic  iwait, dwait, ramREN, ramWEN;
  word_t iload, dload, ramaddr, ramstore;

  int n_chk = 0;
  int n_bad = 0;

  // Reference model: who holds the RAM (0 none, 1 fetch, 2 data) and the pass-over count.
  int m_owner  = 0;
  int m_streak = 0;

  // Expected outputs for the current cycle
  logic  e_ramREN, e_ramWEN, e_iwait, e_dwait;
  word_t e_ramaddr, e_ramstore;

  mem_arbiter #(.STARVE_MAX(SM)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload),
    .dREN     (dREN),
    .dWEN     (dWEN),
    .daddr    (daddr),
    .dstore   (dstore),
    .dwait    (dwait),
    .dload    (dload),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload),
    .ram_ready(ram_ready)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic model_outputs();
    e_ramREN   = (m_owner == 1) || (m_owner == 2 && dREN && !dWEN);
    e_ramWEN   = (m_owner == 2) && dWEN;
    e_ramaddr  = (m_owner == 1) ? iaddr : (m_owner == 2) ? daddr : 32'h0;
    e_ramstore = (m_owner == 2) ? dstore : 32'h0;
    e_iwait    = !((m_owner == 1) && ram_ready);
    e_dwait    = !((m_owner == 2) && ram_ready);
  endtask

  task automatic model_update();
    bit dreq;
    dreq = dREN || dWEN;
    if (!nRST) begin
      m_owner  = 0;
      m_streak = 0;
    end else if (m_owner == 0) begin
      if (!iREN) m_streak = 0;
      if (dreq && !(iREN && m_streak >= SM)) m_owner = 2;
      else if (iREN) m_owner = 1;
    end else if (m_owner == 1) begin
      if (ram_ready) begin
        m_owner  = 0;
        m_streak = 0;
      end else if (!iREN) m_owner = 0;
    end else begin
      if (ram_ready) begin
        m_owner = 0;
        if (iREN && m_streak < SM) m_streak++;
      end else if (!dreq) m_owner = 0;
    end
  endtask

  // Advance one clock; inputs change only on the falling edge.
  task automatic tick();
    @(posedge CLK);
    model_update();
    @(negedge CLK);
  endtask

  task automatic idle_inputs();
    iREN = 0; dREN = 0; dWEN = 0; ram_ready = 0;
    iaddr = 0; daddr = 0; dstore = 0; ramload = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    nRST = 0;
    tick();
    nRST = 1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_chk++;
    if (ramREN !== 1'b0 || ramWEN !== 1'b0 || iwait !== 1'b1 || dwait !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_outputs: got ren=%b wen=%b iwait=%b dwait=%b want 0 0 1 1",
               ramREN, ramWEN, iwait, dwait);
    end
    n_chk++;
    if (int'(dut.r_streak) != 0) begin
      n_bad++;
      $display("FAIL reset_streak: got %0d want 0", dut.r_streak);
    end
  endtask

  task automatic test_ifetch();
    do_reset();
    iREN = 1; iaddr = 32'h40; ramload = 32'hDEAD_BEEF;
    tick();                          // IDLE -> IBUSY
    for (int k = 0; k < 3; k++) begin
      #1;
      n_chk++;
      if (ramREN !== 1'b1 || ramaddr !== 32'h40 || iwait !== 1'b1) begin
        n_bad++;
        $display("FAIL ifetch_busy%0d: got ren=%b addr=%h iwait=%b want 1 00000040 1",
                 k, ramREN, ramaddr, iwait);
      end
      tick();
    end
    ram_ready = 1;
    #1;
    n_chk++;
    if (iwait !== 1'b0 || iload !== 32'hDEAD_BEEF) begin
      n_bad++;
      $display("FAIL ifetch_done: got iwait=%b iload=%h want 0 deadbeef", iwait, iload);
    end
    tick();
    iREN = 0; ram_ready = 1;        // ram_ready in IDLE must be ignored
    #1;
    n_chk++;
    if (ramREN !== 1'b0 || iwait !== 1'b1 || dwait !== 1'b1) begin
      n_bad++;
      $display("FAIL ifetch_idle: got ren=%b iwait=%b dwait=%b want 0 1 1", ramREN, iwait, dwait);
    end
    tick();
  endtask

  task automatic test_priority();
    do_reset();
    iREN = 1; dREN = 1; iaddr = 32'h111; daddr = 32'h222;
    tick();
    #1;
    n_chk++;
    if (ramaddr !== 32'h222 || ramREN !== 1'b1) begin
      n_bad++;
      $display("FAIL prio_data_first: got addr=%h ren=%b want 00000222 1", ramaddr, ramREN);
    end
    ram_ready = 1;
    tick();
    dREN = 0; ram_ready = 0;
    tick();
    #1;
    n_chk++;
    if (ramaddr !== 32'h111 || ramREN !== 1'b1) begin
      n_bad++;
      $display("FAIL prio_fetch_next: got addr=%h ren=%b want 00000111 1", ramaddr, ramREN);
    end
    ram_ready = 1;
    tick();
  endtask

  task automatic test_starve();
    logic [7:0] grants[$];
    string      want;
    want = "DDDDIDDDDI";
    do_reset();
    iREN = 1; dREN = 1; ram_ready = 1; iaddr = 32'h111; daddr = 32'h222;
    for (int c = 0; c < 24; c++) begin
      #1;
      if (ramREN || ramWEN) grants.push_back((ramaddr == 32'h111) ? "I" : "D");
      tick();
    end
    n_chk++;
    if (grants.size() < want.len()) begin
      n_bad++;
      $display("FAIL starve_count: got %0d grants want >= %0d", grants.size(), want.len());
    end else begin
      for (int k = 0; k < want.len(); k++) begin
        n_chk++;
        if (grants[k] !== want[k]) begin
          n_bad++;
          $display("FAIL starve_grant%0d: got %s want %s", k, grants[k], want[k]);
        end
      end
    end
  endtask

  task automatic test_write();
    do_reset();
    dREN = 1; dWEN = 1; daddr = 32'h100; dstore = 32'h1234_5678;
    tick();
    #1;
    n_chk++;
    if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramstore !== 32'h1234_5678 ||
        ramaddr !== 32'h100) begin
      n_bad++;
      $display("FAIL write: got wen=%b ren=%b store=%h addr=%h want 1 0 12345678 00000100",
               ramWEN, ramREN, ramstore, ramaddr);
    end
    ram_ready = 1;
    #1;
    n_chk++;
    if (dwait !== 1'b0) begin
      n_bad++;
      $display("FAIL write_done: got dwait=%b want 0", dwait);
    end
    tick();
  endtask

  task automatic test_abort();
    do_reset();
    iREN = 1; dREN = 1; ram_ready = 1;
    tick();                          // IDLE -> DBUSY
    tick();                          // completes, streak 1
    ram_ready = 0;
    tick();                          // IDLE -> DBUSY
    tick();                          // waiting
    dREN = 0;
    #1;
    n_chk++;
    if (dwait !== 1'b1) begin
      n_bad++;
      $display("FAIL abort_dwait: got %b want 1", dwait);
    end
    tick();
    iREN = 0;
    #1;
    n_chk++;
    if (ramREN !== 1'b0 || ramWEN !== 1'b0 || dwait !== 1'b1) begin
      n_bad++;
      $display("FAIL abort_idle: got ren=%b wen=%b dwait=%b want 0 0 1", ramREN, ramWEN, dwait);
    end
    n_chk++;
    if (int'(dut.r_streak) != 1) begin
      n_bad++;
      $display("FAIL abort_streak: got %0d want 1", dut.r_streak);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    iREN = 1; dREN = 1; ram_ready = 1;
    tick(); tick();                  // one data completion -> streak 1
    dREN = 0; ram_ready = 0;
    tick();                          // IDLE -> IBUSY
    nRST = 0;
    tick();
    nRST = 1;
    #1;
    n_chk++;
    if (ramREN !== 1'b0 || iwait !== 1'b1 || int'(dut.r_streak) != 0) begin
      n_bad++;
      $display("FAIL reset_mid: got ren=%b iwait=%b streak=%0d want 0 1 0",
               ramREN, iwait, dut.r_streak);
    end
    iREN = 0;
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      nRST      = ($urandom_range(0, 39) != 0);
      iREN      = ($urandom_range(0, 9) < 7);
      dREN      = ($urandom_range(0, 9) < 5);
      dWEN      = ($urandom_range(0, 9) < 3);
      ram_ready = $urandom_range(0, 1);
      iaddr     = $urandom;
      daddr     = $urandom;
      dstore    = $urandom;
      ramload   = $urandom;
      #1;
      model_outputs();
      n_chk++;
      if (ramREN !== e_ramREN || ramWEN !== e_ramWEN) begin
        n_bad++;
        $display("FAIL rand_strobe c%0d: got ren=%b wen=%b want %b %b",
                 c, ramREN, ramWEN, e_ramREN, e_ramWEN);
      end
      n_chk++;
      if (ramaddr !== e_ramaddr || ramstore !== e_ramstore) begin
        n_bad++;
        $display("FAIL rand_bus c%0d: got addr=%h store=%h want %h %h",
                 c, ramaddr, ramstore, e_ramaddr, e_ramstore);
      end
      n_chk++;
      if (iwait !== e_iwait || dwait !== e_dwait) begin
        n_bad++;
        $display("FAIL rand_wait c%0d: got iwait=%b dwait=%b want %b %b",
                 c, iwait, dwait, e_iwait, e_dwait);
      end
      n_chk++;
      if (iload !== ramload || dload !== ramload) begin
        n_bad++;
        $display("FAIL rand_load c%0d: got iload=%h dload=%h want %h", c, iload, dload, ramload);
      end
      n_chk++;
      if (int'(dut.r_streak) != m_streak) begin
        n_bad++;
        $display("FAIL rand_streak c%0d: got %0d want %0d", c, dut.r_streak, m_streak);
      end
      tick();
    end
  endtask

  initial begin
    nRST = 0;
    idle_inputs();
    @(negedge CLK);
    test_reset();
    test_ifetch();
    test_priority();
    test_starve();
    test_write();
    test_abort();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4: max consecutive data grants while an instruction request waits.
REQ-002 SHALL have port CLK  in  1  system clock, rising-edge active.
REQ-003 SHALL have port nRST  in  1  reset, synchronous, active-low.
REQ-004 SHALL have port iREN  in  1  instruction fetch request.
REQ-005 SHALL have port iaddr  in  32  instruction word address.
REQ-006 SHALL have ports iwait (out, 1, fetch not complete) and iload (out, 32, fetched word).
REQ-007 SHALL have ports dREN (in, 1, data read request) and dWEN (in, 1, data write request).
REQ-008 SHALL have ports daddr (in, 32, data address) and dstore (in, 32, write data).
REQ-009 SHALL have ports dwait (out, 1, data access not complete) and dload (out, 32, read data).
REQ-010 SHALL have RAM-side ports ramREN (out, 1), ramWEN (out, 1), ramaddr (out, 32), ramstore (out, 32), ramload (in, 32) and ram_ready (in, 1: access completes this cycle).

Function
REQ-011 SHALL implement FSM states IDLE, IBUSY, DBUSY; state register updates on CLK rising edge only.
REQ-012 In IDLE, any pending dREN|dWEN SHALL move the FSM to DBUSY, else iREN SHALL move it to IBUSY, else it stays IDLE; exception per REQ-013.
REQ-013 When iREN and data are both pending in IDLE and streak counter == STARVE_MAX, SHALL go to IBUSY.
REQ-014 Streak counter SHALL increment, saturating at STARVE_MAX, on each DBUSY completion while iREN is high; SHALL clear on any IBUSY completion or whenever iREN is low in IDLE.
REQ-015 In IDLE, ramREN and ramWEN SHALL be 0; ramaddr and ramstore don't-care (drive 0).
REQ-016 In IBUSY: ramREN=1, ramWEN=0, ramaddr=iaddr.
REQ-017 In DBUSY: ramWEN=dWEN, ramREN=dREN & ~dWEN (write wins if both high), ramaddr=daddr, ramstore=dstore.
REQ-018 iwait SHALL be 0 only in the IBUSY cycle with ram_ready=1; dwait SHALL be 0 only in the DBUSY cycle with ram_ready=1; otherwise 1.
REQ-019 iload and dload SHALL combinationally pass ramload; valid only in their completion cycle.
REQ-020 On completion (ram_ready=1 in xBUSY), the next state SHALL be IDLE; minimum one IDLE cycle between accesses; minimum latency request-to-completion is 2 cycles.
REQ-021 If the granted request drops (IBUSY & ~iREN, DBUSY & ~dREN & ~dWEN) before ram_ready, SHALL return to IDLE next cycle without completion and without counter update.
REQ-022 ram_ready in IDLE SHALL be ignored.
REQ-023 Address/data changes by a requester mid-access SHALL pass through unregistered; requesters hold them stable (protocol rule, not checked).

Reset
REQ-024 When nRST=0 at a rising edge: state=IDLE, streak counter=0; outputs then ramREN=0, ramWEN=0, iwait=1, dwait=1.
REQ-025 Reset mid-access SHALL abandon the access with no completion signalled.

Structure
REQ-026 State enum (IDLE, IBUSY, DBUSY) SHALL be added to cpu_types_pkg; ports use word_t.
REQ-027 Single flat module; no sub-module; counter width $clog2(STARVE_MAX+1).

Verification
REQ-028 iREN=1, iaddr=0x40, ram_ready after 3 BUSY cycles, ramload=0xDEADBEEF -> iwait low one cycle with iload=0xDEADBEEF, FSM IDLE next.
REQ-029 iREN and dREN both high in IDLE, streak=0 -> DBUSY first, ramaddr=daddr; IBUSY after data completion.
REQ-030 STARVE_MAX=4, iREN and dREN held high, ram_ready=1 always -> grants D,D,D,D,I,D,... pattern.
REQ-031 dREN=dWEN=1, daddr=0x100, dstore=0x12345678 -> ramWEN=1, ramREN=0, ramstore=0x12345678.
REQ-032 dREN dropped in DBUSY before ram_ready -> IDLE next cycle, dwait stays 1, counter unchanged.
REQ-033 nRST=0 during IBUSY -> next cycle IDLE, ramREN=0, iwait=1, counter=0.
